shadow_chain_rx: RTL and testbench
==================================

Name: shadow_chain_rx

Overview:
- Receive-side endpoint for the shadow capture dump chains.
- Requests a dump from a shadow_capture instance and deserializes its serial chain stream (chains_out / chains_out_vld / chains_out_done) into WORD_W-bit words.
- Buffers the words in a FIFO for the debug host to read with a valid/ready handshake.
- Sits between per-block shadow capture logic (e.g. a 115-bit LSU tag datapath snapshot) and the debug readout fabric, on the shadow clock domain.

Parameters:
- WORD_W, 32, width of assembled output words (power of 2, 8..64).
- FIFO_DEPTH, 8, number of FIFO entries (power of 2, >=2).
- CNT_W, 16, width of the received-bit counter; saturates at all-ones.
- TIMEOUT_CYC, 4096, watchdog limit in sh_clk cycles (used only with SHADOW_RX_TIMEOUT_EN).

Ports:
- sh_clk, input, 1, shadow/data clock; all logic is on its rising edge.
- sh_rst_n, input, 1, asynchronous active-low reset.
- dump_req, input, 1, host pulse or level that starts a dump; sampled only in IDLE.
- dump_en, output, 1, one-cycle dump-enable pulse to shadow_capture.
- chain_in, input, 1, serial chain data from shadow_capture chains_out.
- chain_in_vld, input, 1, chain_in is valid this cycle.
- chain_in_done, input, 1, end of chain; may coincide with the last valid bit.
- rd_data, output, WORD_W, FIFO head word.
- rd_valid, output, 1, FIFO non-empty.
- rd_ready, input, 1, host pops the word when rd_valid && rd_ready.
- bit_count, output, CNT_W, bits received in the current or last dump.
- busy, output, 1, state is not IDLE.
- done, output, 1, sticky dump-complete flag, held until the next dump starts.
- overflow, output, 1, sticky flag: a word was dropped because the FIFO was full.
- timeout, output, 1, sticky watchdog flag (tied to 0 without SHADOW_RX_TIMEOUT_EN).

Behaviour:
- Reset values: dump_en=0, rd_valid=0, rd_data=0, bit_count=0, busy=0, done=0, overflow=0, timeout=0; FIFO empty; state IDLE.
- State machine:
  - IDLE: dump_req=1 moves to REQ. done, overflow, timeout, bit_count and the shift register clear on that transition. FIFO contents are retained.
  - REQ: dump_en=1 for exactly this one cycle, then RECV.
  - RECV: each cycle with chain_in_vld=1:
    - shift chain_in into bit position ptr of the assembling word; the first received bit is word bit 0 (LSB-first);
    - ptr increments and bit_count increments (saturating);
    - when ptr wraps from WORD_W-1 to 0, the completed word is pushed.
    - chain_in_done=1 moves to FLUSH after that cycle's bit, if any, has been accepted.
  - FLUSH: if ptr!=0, push the partial word zero-padded in the upper bits. Then DONE.
  - DONE: set done=1, go to IDLE (one cycle).
- Push latency: a word completed on cycle N is visible on rd_data/rd_valid at N+1 if the FIFO was empty.
- FIFO full on push: the word is dropped, overflow set, deserialization continues.
- Simultaneous push and pop when full: the pop frees the slot and the push succeeds, so no overflow.
- Pop when empty: no effect.
- chain_in_vld or chain_in_done outside RECV: ignored.
- dump_req during a dump: ignored.
- Reset mid-dump: immediate return to IDLE, FIFO flushed, all flags cleared; a partial word is discarded.
- Expected word count for an N-bit chain: ceil(N/WORD_W). With the defaults, 115 bits gives 4 words; the last word holds bits 96..114 with bits 19..31 zero.

Optional Feature:
- Macro: SHADOW_RX_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to RECV and on every valid bit, and increments otherwise. On reaching TIMEOUT_CYC it sets timeout=1 and forces FLUSH, so the partial word is still pushed.
- Undefined: no counter; the timeout output is constant 0; RECV waits indefinitely for chain_in_done.

Decomposition:
- Package shadow_rx_pkg: state enum (IDLE, REQ, RECV, FLUSH, DONE) and the default WORD_W/FIFO_DEPTH constants.
- Sub-module shadow_rx_fifo: synchronous FIFO with async active-low reset and ports push, push_data, pop, full, empty, head data. The FSM and deserializer stay in the top.

Test Plan:
- Reset, then dump_req, then 115 valid bits of pattern i%3==0, with done on bit 115 -> dump_en pulses exactly once; 4 words popped; word0=32'h49249249; bit_count=115; done=1; overflow=0.
- 64 bits with chain_in_vld toggling every other cycle and done arriving one cycle after the last bit -> exactly 2 words, no padding word, bit_count=64.
- rd_ready held 0 with a 320-bit chain and FIFO_DEPTH=8 -> 8 words stored, words 9-10 dropped, overflow=1; after draining, the 8 words equal bits 0..255.
- sh_rst_n asserted mid-RECV after 40 bits -> rd_valid=0, busy=0 immediately; a new dump of 32 bits yields exactly 1 word.
- dump_req held high through a full 33-bit dump -> the second dump starts only after DONE; 33 bits give 2 words, word1=bit32 in LSB with upper bits zero.
- With SHADOW_RX_TIMEOUT_EN and TIMEOUT_CYC=16: 10 bits, then the stream stalls -> timeout=1 sixteen cycles after the last bit, 1 padded word pushed, done=1.

Source files
------------

// File: rtl/shadow_rx_pkg.sv
// Shared types and default sizes for the shadow chain receive endpoint.
package shadow_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RECV,
        FLUSH,
        DONE
    } state_t;

    localparam int unsigned DEF_WORD_W     = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/shadow_chain_rx_if.sv
// Debug-host readout port: FIFO head word with a valid/ready pop handshake.
interface shadow_chain_rx_if
    import shadow_rx_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
);
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (output rd_data, output rd_valid, input  rd_ready);
    modport slave  (input  rd_data, input  rd_valid, output rd_ready);
endinterface

// File: rtl/shadow_rx_fifo.sv
// Synchronous word FIFO; a push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module shadow_rx_fifo
    import shadow_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WORD_W,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so the readout bus is clean after reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/shadow_chain_rx.sv
// Requests a shadow dump, deserializes the LSB-first chain stream into words and queues them for the host.
// Optional watchdog on a stalled stream: define SHADOW_RX_TIMEOUT_EN.
module shadow_chain_rx
    import shadow_rx_pkg::*;
#(
    parameter int unsigned WORD_W      = DEF_WORD_W,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic               sh_clk,
    input  logic               sh_rst_n,
    input  logic               dump_req,
    output logic               dump_en,
    input  logic               chain_in,
    input  logic               chain_in_vld,
    input  logic               chain_in_done,
    shadow_chain_rx_if.master  rd,
    output logic [CNT_W-1:0]   bit_count,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               timeout
);
    localparam int unsigned PTR_W = $clog2(WORD_W);

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [WORD_W-1:0] shreg, word_next, push_data;
    logic              push, pop, full, empty, last, wd_hit;

    assign pop         = rd.rd_valid && rd.rd_ready;
    assign rd.rd_valid = !empty;

    always_comb begin
        last           = (ptr == PTR_W'(WORD_W - 1));
        word_next      = shreg;
        word_next[ptr] = chain_in;
        push           = 1'b0;
        push_data      = shreg;
        if (state == RECV && chain_in_vld && last) begin
            push      = 1'b1;
            push_data = word_next;
        end else if (state == FLUSH && ptr != '0) begin
            push = 1'b1;
        end
    end

`ifdef SHADOW_RX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog;

    assign wd_hit = (state == RECV) && !chain_in_vld && !chain_in_done
                    && (wdog == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sh_clk or negedge sh_rst_n) begin
        if (!sh_rst_n) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE && dump_req) timeout <= 1'b0;
            if (wd_hit)                    timeout <= 1'b1;
            if (state == REQ || chain_in_vld) wdog <= '0;
            else if (state == RECV)           wdog <= wdog + WD_W'(1);
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge sh_clk or negedge sh_rst_n) begin
        if (!sh_rst_n) begin
            state     <= IDLE;
            dump_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bit_count <= '0;
            shreg     <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: if (dump_req) begin
                    state     <= REQ;
                    dump_en   <= 1'b1;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    overflow  <= 1'b0;
                    bit_count <= '0;
                    shreg     <= '0;
                    ptr       <= '0;
                end
                REQ: begin
                    dump_en <= 1'b0;
                    state   <= RECV;
                end
                RECV: begin
                    if (chain_in_vld) begin
                        // Clearing on wrap keeps upper bits zero for a padded final word.
                        shreg <= last ? '0 : word_next;
                        ptr   <= ptr + PTR_W'(1);
                        if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
                    end
                    if (chain_in_done || wd_hit) state <= FLUSH;
                end
                FLUSH: begin
                    shreg <= '0;
                    ptr   <= '0;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    shadow_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sh_clk),
        .rst_n     (sh_rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (rd.rd_data)
    );
endmodule

// File: tb/tb_shadow_chain_rx.sv
// Self-checking bench for shadow_chain_rx: vector table, hand-written corner sequences, randomized dumps.
module tb_shadow_chain_rx;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic          sh_clk = 1'b0;
    logic          sh_rst_n = 1'b0;
    logic          dump_req = 1'b0;
    logic          chain_in = 1'b0;
    logic          chain_in_vld = 1'b0;
    logic          chain_in_done = 1'b0;
    logic          dump_en, busy, done, overflow, timeout;
    logic [CW-1:0] bit_count;

    shadow_chain_rx_if #(.WORD_W(W)) rd_if ();

    shadow_chain_rx #(
        .WORD_W      (W),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW),
        .TIMEOUT_CYC (16)
    ) dut (
        .sh_clk        (sh_clk),
        .sh_rst_n      (sh_rst_n),
        .dump_req      (dump_req),
        .dump_en       (dump_en),
        .chain_in      (chain_in),
        .chain_in_vld  (chain_in_vld),
        .chain_in_done (chain_in_done),
        .rd            (rd_if),
        .bit_count     (bit_count),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .timeout       (timeout)
    );

    always #5 sh_clk = ~sh_clk;

    int errors = 0;
    int checks = 0;

    // Monitor: popped words and dump_en pulses, sampled away from the active edge.
    logic [W-1:0] got[$];
    int           en_cnt = 0;
    always @(negedge sh_clk) begin
        if (rd_if.rd_valid && rd_if.rd_ready) got.push_back(rd_if.rd_data);
        if (dump_en) en_cnt++;
    end

    logic bits [0:511];

    typedef struct {
        int          n;
        int          gap;
        bit          done_late;
        int          rdy_mode;   // 0 ready low, 1 ready high, 2 random
        int          pat;        // 0 i%3==0, 1 all ones, 2 random
        int          exp_words;
        int          exp_bits;
        bit          exp_ovf;
        logic [31:0] exp_w0;
        bit          chk_w0;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sh_clk);
        #1;
    endtask

    task automatic tick(input int rdy_mode);
        case (rdy_mode)
            0:       rd_if.rd_ready = 1'b0;
            1:       rd_if.rd_ready = 1'b1;
            default: rd_if.rd_ready = 1'($urandom_range(0, 1));
        endcase
        step();
    endtask

    task automatic fill_bits(input int pat);
        for (int i = 0; i < 512; i++)
            case (pat)
                0:       bits[i] = (i % 3 == 0);
                1:       bits[i] = 1'b1;
                default: bits[i] = 1'($urandom_range(0, 1));
            endcase
    endtask

    // Spec-level model: word k holds chain bits k*W .. k*W+W-1, LSB first, zero past the chain end.
    function automatic logic [W-1:0] model_word(input int k, input int n);
        logic [W-1:0] w = '0;
        for (int j = 0; j < W; j++)
            if (k * W + j < n) w[j] = bits[k * W + j];
        return w;
    endfunction

    task automatic start_dump(input int rdy_mode, input bit hold_req);
        int t = 0;
        dump_req = 1'b1;
        do begin tick(rdy_mode); t++; end while (!dump_en && t < 10);
        check("dump_en_seen", dump_en, 1);
        dump_req = hold_req;
        tick(rdy_mode);
    endtask

    task automatic send_bits(input int n, input int gap, input bit with_done, input int rdy_mode);
        int g;
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            for (int k = 0; k < g; k++) begin
                chain_in_vld  = 1'b0;
                chain_in_done = 1'b0;
                chain_in      = 1'($urandom_range(0, 1));
                tick(rdy_mode);
            end
            chain_in_vld  = 1'b1;
            chain_in      = bits[i];
            chain_in_done = with_done && (i == n - 1);
            tick(rdy_mode);
        end
        chain_in_vld  = 1'b0;
        chain_in_done = 1'b0;
    endtask

    task automatic wait_done(input int rdy_mode);
        int t = 0;
        while (!done && t < 30) begin tick(rdy_mode); t++; end
        check("done_flag", done, 1);
    endtask

    task automatic run_dump(input int n, input int gap, input bit done_late, input int rdy_mode);
        start_dump(rdy_mode, 1'b0);
        send_bits(n, gap, !done_late, rdy_mode);
        if (done_late || n == 0) begin
            chain_in_done = 1'b1;
            tick(rdy_mode);
            chain_in_done = 1'b0;
        end
        wait_done(rdy_mode);
    endtask

    task automatic drain_check(input int n, input int exp_words, input int base);
        int t = 0;
        int cnt;
        rd_if.rd_ready = 1'b1;
        while (rd_if.rd_valid && t < 40) begin step(); t++; end
        check("drained", rd_if.rd_valid, 0);
        cnt = got.size() - base;
        check("word_count", cnt, exp_words);
        for (int k = 0; k < cnt && k < exp_words; k++)
            check($sformatf("word%0d", k), got[base + k], model_word(k, n));
        rd_if.rd_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int base, en0, n, ewords;
        bit dl;

        tbl[0] = '{115, 0,  1'b0, 1, 0, 4, 115, 1'b0, 32'h49249249, 1'b1};
        tbl[1] = '{64,  1,  1'b1, 1, 2, 2, 64,  1'b0, 32'h0,        1'b0};
        tbl[2] = '{320, 0,  1'b0, 0, 2, 8, 255, 1'b1, 32'h0,        1'b0};
        tbl[3] = '{1,   0,  1'b0, 1, 1, 1, 1,   1'b0, 32'h00000001, 1'b1};
        tbl[4] = '{32,  -1, 1'b0, 2, 2, 1, 32,  1'b0, 32'h0,        1'b0};
        tbl[5] = '{0,   0,  1'b1, 1, 2, 0, 0,   1'b0, 32'h0,        1'b0};

        rd_if.rd_ready = 1'b0;
        step(); step();
        check("rst_dump_en",  dump_en, 0);
        check("rst_rd_valid", rd_if.rd_valid, 0);
        check("rst_rd_data",  rd_if.rd_data, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout",  timeout, 0);
        sh_rst_n = 1'b1;
        step();

        // Chain strobes in IDLE must be ignored.
        en0 = en_cnt;
        chain_in_vld = 1'b1; chain_in = 1'b1; chain_in_done = 1'b1;
        repeat (3) step();
        chain_in_vld = 1'b0; chain_in_done = 1'b0;
        check("idle_busy",     busy, 0);
        check("idle_bits",     bit_count, 0);
        check("idle_rd_valid", rd_if.rd_valid, 0);
        check("idle_no_en",    en_cnt - en0, 0);

        for (int r = 0; r < 6; r++) begin
            fill_bits(tbl[r].pat);
            base = got.size();
            en0  = en_cnt;
            run_dump(tbl[r].n, tbl[r].gap, tbl[r].done_late, tbl[r].rdy_mode);
            check($sformatf("v%0d_bit_count", r), bit_count, tbl[r].exp_bits);
            check($sformatf("v%0d_overflow", r), overflow, tbl[r].exp_ovf);
            check($sformatf("v%0d_timeout", r), timeout, 0);
            check($sformatf("v%0d_en_pulses", r), en_cnt - en0, 1);
            check($sformatf("v%0d_busy", r), busy, 0);
            drain_check(tbl[r].n, tbl[r].exp_words, base);
            if (tbl[r].chk_w0 && got.size() > base)
                check($sformatf("v%0d_word0", r), got[base], tbl[r].exp_w0);
        end

        // Reset in the middle of RECV discards everything.
        fill_bits(2);
        start_dump(0, 1'b0);
        send_bits(40, 0, 1'b0, 0);
        check("pre_rst_rd_valid", rd_if.rd_valid, 1);
        sh_rst_n = 1'b0;
        #1;
        check("mid_rst_rd_valid", rd_if.rd_valid, 0);
        check("mid_rst_busy",     busy, 0);
        check("mid_rst_bits",     bit_count, 0);
        #2 sh_rst_n = 1'b1;
        step();
        base = got.size();
        run_dump(32, 0, 1'b0, 1);
        check("post_rst_bits", bit_count, 32);
        drain_check(32, 1, base);

        // dump_req held high: second dump begins only after DONE.
        fill_bits(2);
        bits[32] = 1'b1;
        base = got.size();
        en0  = en_cnt;
        start_dump(1, 1'b1);
        send_bits(33, 0, 1'b1, 1);
        wait_done(1);
        check("hold_single_en", en_cnt - en0, 1);
        check("hold_busy_idle", busy, 0);
        check("hold_bits",      bit_count, 33);
        tick(1);
        check("hold_restart_en",   dump_en, 1);
        check("hold_restart_done", done, 0);
        dump_req = 1'b0;
        tick(1);
        chain_in_done = 1'b1;
        tick(1);
        chain_in_done = 1'b0;
        wait_done(1);
        drain_check(33, 2, base);
        if (got.size() > base + 1) check("hold_word1", got[base + 1], 32'h1);

`ifdef SHADOW_RX_TIMEOUT_EN
        begin
            int k = 0;
            fill_bits(2);
            base = got.size();
            start_dump(1, 1'b0);
            send_bits(10, 0, 1'b0, 1);
            while (!timeout && k < 40) begin tick(1); k++; end
            check("to_cycles", k, 16);
            check("to_flag",   timeout, 1);
            wait_done(1);
            drain_check(10, 1, base);
        end
`endif

        // Randomized dumps, at most one FIFO's worth so no drops are possible.
        for (int it = 0; it < 6; it++) begin
            n      = $urandom_range(1, 256);
            dl     = 1'($urandom_range(0, 1));
            ewords = (n + W - 1) / W;
            fill_bits(2);
            base = got.size();
            run_dump(n, -1, dl, 2);
            check($sformatf("r%0d_bit_count", it), bit_count, (n > 255) ? 255 : n);
            check($sformatf("r%0d_overflow", it), overflow, 0);
            drain_check(n, ewords, base);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
